// File: rtl/fp_div_round_pack.sv
// ---------------------------------------------------------------------------
// fp_div_round_pack
//
// Post-divide stage of the single-precision floating-point divider. It takes
// the raw quotient from the mantissa divider, normalises it, rounds it to
// nearest-even, checks the exponent range (no subnormals: flush to zero) and
// packs an IEEE-754 word. NaN / infinity / zero results that the operand
// classifier flags bypass the arithmetic path.
//
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  input handshake; one bundle in flight at a time
//   sign                 result sign
//   exp_in               signed biased exponent ea-eb+BIAS (two's complement)
//   q                    quotient, q[MANT_W+2] has weight 2^0
//   rem_nz               divider remainder is non-zero
//   is_nan/is_inf/is_zero special-result indications
//   out_valid/out_ready  output handshake
//   result               packed float {sign, exp, frac}
//   overflow, underflow, inexact  exception flags, valid with result
// ---------------------------------------------------------------------------
module fp_div_round_pack #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int BIAS   = 127
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      sign,
    input  logic [EXP_W+1:0]          exp_in,
    input  logic [MANT_W+2:0]         q,
    input  logic                      rem_nz,
    input  logic                      is_nan,
    input  logic                      is_inf,
    input  logic                      is_zero,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W:0]     result,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      inexact
);

    // One extra exponent bit beyond the input so that exp_in-1 and the
    // rounding increment can never wrap.
    localparam int XW = EXP_W + 3;
    localparam int RW = EXP_W + MANT_W + 1;

    // The all-ones exponent code equals 2*BIAS+1 for IEEE formats.
    localparam logic signed [XW-1:0] EXP_MAX  = XW'(2 * BIAS + 1);
    localparam logic [EXP_W-1:0]     EXP_ONES = EXP_W'(2 * BIAS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]              state_q,     state_d;
    logic                    sign_q,      sign_d;
    logic signed [XW-1:0]    exp_q,       exp_d;
    logic [MANT_W+2:0]       quo_q,       quo_d;
    logic                    rem_nz_q,    rem_nz_d;
    logic                    nan_q,       nan_d;
    logic                    inf_q,       inf_d;
    logic                    zero_q,      zero_d;
    logic [MANT_W:0]         mant_q,      mant_d;
    logic                    guard_q,     guard_d;
    logic                    sticky_q,    sticky_d;
    logic [RW-1:0]           result_q,    result_d;
    logic                    overflow_q,  overflow_d;
    logic                    underflow_q, underflow_d;
    logic                    inexact_q,   inexact_d;

    logic                    round_inc;
    logic [MANT_W:0]         frac_sum;
    logic                    frac_carry;
    logic [MANT_W-1:0]       frac_rnd;
    logic signed [XW-1:0]    exp_rnd;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign inexact   = inexact_q;

    // Round-to-nearest-even on the stored fraction. A carry out of the
    // fraction turns 1.111..1 into 10.000..0, which renormalises to 1.0 with
    // the exponent bumped; the fraction field is then already all zeros.
    // The exponent only moves if the hidden bit was set, so a (theoretically
    // unreachable) hidden-bit-zero mantissa simply gains its leading one.
    always_comb begin
        round_inc  = guard_q & (sticky_q | mant_q[0]);
        frac_sum   = {1'b0, mant_q[MANT_W-1:0]} + {{MANT_W{1'b0}}, round_inc};
        frac_carry = frac_sum[MANT_W] & mant_q[MANT_W];
        frac_rnd   = frac_sum[MANT_W-1:0];
        exp_rnd    = exp_q + {{(XW-1){1'b0}}, frac_carry};
    end

    // Next-state and datapath logic for the four-state sequencer.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        quo_d       = quo_q;
        rem_nz_d    = rem_nz_q;
        nan_d       = nan_q;
        inf_d       = inf_q;
        zero_d      = zero_q;
        mant_d      = mant_q;
        guard_d     = guard_q;
        sticky_d    = sticky_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        inexact_d   = inexact_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d   = sign;
                    exp_d    = {exp_in[EXP_W+1], exp_in};
                    quo_d    = q;
                    rem_nz_d = rem_nz;
                    nan_d    = is_nan;
                    inf_d    = is_inf;
                    zero_d   = is_zero;
                    state_d  = S_NORM;
                end
            end

            // The quotient of two [1,2) mantissas lies in (1/2, 2), so at
            // most a one-bit left shift is needed.
            S_NORM: begin
                if (quo_q[MANT_W+2]) begin
                    mant_d   = quo_q[MANT_W+2:2];
                    guard_d  = quo_q[1];
                    sticky_d = quo_q[0] | rem_nz_q;
                end else begin
                    mant_d   = quo_q[MANT_W+1:1];
                    guard_d  = quo_q[0];
                    sticky_d = rem_nz_q;
                    exp_d    = exp_q - XW'(1);
                end
                state_d = S_ROUND;
            end

            // Range checks first, then special operands override everything.
            S_ROUND: begin
                if (exp_rnd >= EXP_MAX) begin
                    result_d    = {sign_q, EXP_ONES, {MANT_W{1'b0}}};
                    overflow_d  = 1'b1;
                    underflow_d = 1'b0;
                    inexact_d   = 1'b1;
                end else if (exp_rnd <= 0) begin
                    result_d    = {sign_q, {(RW-1){1'b0}}};
                    overflow_d  = 1'b0;
                    underflow_d = 1'b1;
                    inexact_d   = 1'b1;
                end else begin
                    result_d    = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    inexact_d   = guard_q | sticky_q;
                end

                if (nan_q || inf_q || zero_q) begin
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    inexact_d   = 1'b0;
                    if (nan_q) begin
                        result_d = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};
                    end else if (inf_q) begin
                        result_d = {sign_q, EXP_ONES, {MANT_W{1'b0}}};
                    end else begin
                        result_d = {sign_q, {(RW-1){1'b0}}};
                    end
                end
                state_d = S_OUT;
            end

            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All state, including the output word and flags, clears on reset so an
    // in-flight bundle is dropped without trace.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            quo_q       <= '0;
            rem_nz_q    <= 1'b0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
            mant_q      <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            quo_q       <= quo_d;
            rem_nz_q    <= rem_nz_d;
            nan_q       <= nan_d;
            inf_q       <= inf_d;
            zero_q      <= zero_d;
            mant_q      <= mant_d;
            guard_q     <= guard_d;
            sticky_q    <= sticky_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            inexact_q   <= inexact_d;
        end
    end

endmodule

// File: tb/tb_fp_div_round_pack.sv
// ---------------------------------------------------------------------------
// tb_fp_div_round_pack
//
// Directed bench for fp_div_round_pack. Each vector is driven through the
// input handshake, the output is awaited with a bounded cycle count and the
// packed result plus flags are compared with hand-computed values.
// ---------------------------------------------------------------------------
module tb_fp_div_round_pack;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [9:0]  exp_in;
    logic [25:0] q;
    logic        rem_nz;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    int vectors;
    int miscompares;

    fp_div_round_pack #(
        .EXP_W  (8),
        .MANT_W (23),
        .BIAS   (127)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign      (sign),
        .exp_in    (exp_in),
        .q         (q),
        .rem_nz    (rem_nz),
        .is_nan    (is_nan),
        .is_inf    (is_inf),
        .is_zero   (is_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point; every check in the bench goes through here.
    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for in_ready, then presents one bundle for exactly one
    // accepting edge. Returns #1 after that accept edge.
    task automatic applyStimulus(input logic s, input logic [9:0] e,
                                 input logic [25:0] qq, input logic rnz,
                                 input logic n, input logic i, input logic z);
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) checkValue("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        sign     = s;
        exp_in   = e;
        q        = qq;
        rem_nz   = rnz;
        is_nan   = n;
        is_inf   = i;
        is_zero  = z;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts rising edges from the accept edge (inclusive) until out_valid is
    // seen; accept -> NORM -> ROUND -> OUT puts it on the third edge.
    task automatic waitValid(input string tag);
        int edges;
        edges = 1;
        while (!out_valid && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkValue({tag, "_latency"}, edges, 32'd3);
    endtask

    // Compares the presented result and flags, then completes the output
    // handshake and checks the stage is back to accepting.
    task automatic checkOutput(input string tag, input logic [31:0] expResult,
                               input logic expOv, input logic expUf,
                               input logic expIx);
        checkValue({tag, "_result"},    result,               expResult);
        checkValue({tag, "_overflow"},  {31'd0, overflow},    {31'd0, expOv});
        checkValue({tag, "_underflow"}, {31'd0, underflow},   {31'd0, expUf});
        checkValue({tag, "_inexact"},   {31'd0, inexact},     {31'd0, expIx});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkValue({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
        checkValue({tag, "_in_ready"},   {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sign      = 1'b0;
        exp_in    = '0;
        q         = '0;
        rem_nz    = 1'b0;
        is_nan    = 1'b0;
        is_inf    = 1'b0;
        is_zero   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset_in_ready",  {31'd0, in_ready},  32'd1);
        checkValue("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkValue("reset_result",    result,             32'd0);
        checkValue("reset_flags",     {29'd0, overflow, underflow, inexact}, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // 1.5 exactly: top quotient bit set, nothing discarded
        applyStimulus(1'b0, 10'd127, 26'h3000000, 1'b0, 1'b0, 1'b0, 1'b0);
        waitValid("v1p5");
        checkOutput("v1p5", 32'h3FC00000, 1'b0, 1'b0, 1'b0);

        // 2/3: normalise shift, guard=1 sticky=1 rounds up
        applyStimulus(1'b0, 10'd127, 26'h1555555, 1'b1, 1'b0, 1'b0, 1'b0);
        waitValid("twothirds");
        checkOutput("twothirds", 32'h3F2AAAAB, 1'b0, 1'b0, 1'b1);

        // All-ones mantissa rounds up and carries into the exponent
        applyStimulus(1'b0, 10'd127, 26'h3FFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        waitValid("carry");
        checkOutput("carry", 32'h40000000, 1'b0, 1'b0, 1'b1);

        // Exact tie with even LSB: no increment, still inexact
        applyStimulus(1'b0, 10'd127, 26'h2000002, 1'b0, 1'b0, 1'b0, 1'b0);
        waitValid("tie_even");
        checkOutput("tie_even", 32'h3F800000, 1'b0, 1'b0, 1'b1);

        // Largest finite exponent is still in range
        applyStimulus(1'b0, 10'd254, 26'h2000000, 1'b0, 1'b0, 1'b0, 1'b0);
        waitValid("max_exp");
        checkOutput("max_exp", 32'h7F000000, 1'b0, 1'b0, 1'b0);

        // Exponent 255 overflows to infinity
        applyStimulus(1'b0, 10'd255, 26'h2000000, 1'b0, 1'b0, 1'b0, 1'b0);
        waitValid("ovf");
        checkOutput("ovf", 32'h7F800000, 1'b1, 1'b0, 1'b1);

        // Rounding carry from exponent 254 pushes into overflow
        applyStimulus(1'b1, 10'd254, 26'h3FFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        waitValid("ovf_carry");
        checkOutput("ovf_carry", 32'hFF800000, 1'b1, 1'b0, 1'b1);

        // Normalise shift drops exponent 1 to 0: flush to signed zero
        applyStimulus(1'b1, 10'd1, 26'h1000000, 1'b0, 1'b0, 1'b0, 1'b0);
        waitValid("unf");
        checkOutput("unf", 32'h80000000, 1'b0, 1'b1, 1'b1);

        // Negative biased exponent underflows
        applyStimulus(1'b0, 10'h3FB, 26'h2000000, 1'b0, 1'b0, 1'b0, 1'b0);
        waitValid("unf_neg");
        checkOutput("unf_neg", 32'h00000000, 1'b0, 1'b1, 1'b1);

        // NaN beats infinity; canonical quiet NaN with sign cleared
        applyStimulus(1'b1, 10'd127, 26'h3000000, 1'b1, 1'b1, 1'b1, 1'b0);
        waitValid("nan");
        checkOutput("nan", 32'h7FC00000, 1'b0, 1'b0, 1'b0);

        // Infinity overrides an exponent that would otherwise overflow
        applyStimulus(1'b1, 10'd300, 26'h3FFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        waitValid("inf");
        checkOutput("inf", 32'hFF800000, 1'b0, 1'b0, 1'b0);

        // Zero keeps the sign and clears flags
        applyStimulus(1'b1, 10'd127, 26'h3FFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        waitValid("zero");
        checkOutput("zero", 32'h80000000, 1'b0, 1'b0, 1'b0);

        // Output back-pressure: result and flags hold, no new input accepted
        applyStimulus(1'b0, 10'd127, 26'h1555555, 1'b1, 1'b0, 1'b0, 1'b0);
        waitValid("stall");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkValue("stall_result",    result,             32'h3F2AAAAB);
            checkValue("stall_inexact",   {31'd0, inexact},   32'd1);
            checkValue("stall_out_valid", {31'd0, out_valid}, 32'd1);
            checkValue("stall_in_ready",  {31'd0, in_ready},  32'd0);
        end
        checkOutput("stall", 32'h3F2AAAAB, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset while the bundle sits in ROUND
        applyStimulus(1'b0, 10'd255, 26'h2000000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checkValue("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        checkValue("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
        checkValue("rst_mid_result",    result,             32'd0);
        checkValue("rst_mid_flags",     {29'd0, overflow, underflow, inexact}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checkValue("rst_no_emit", {31'd0, out_valid}, 32'd0);
        end

        // Stage recovers and processes a fresh bundle after the reset
        applyStimulus(1'b0, 10'd127, 26'h3000000, 1'b0, 1'b0, 1'b0, 1'b0);
        waitValid("recover");
        checkOutput("recover", 32'h3FC00000, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
